ysyx_23060096_imem_resp: RTL and testbench
==========================================

Name: ysyx_23060096_imem_resp

Overview:
Instruction-memory responder for the npc core: the other end of the core's pc-out / inst-in fetch interface.
- Accepts fetch addresses over a valid/ready request channel.
- Returns the 32-bit instruction word over a valid/ready response channel after a programmable latency.
- Internal word-addressed storage is preloaded by a simple write port driven by the testbench or boot loader.

Parameters:
- DEPTH_WORDS, 4096: storage depth in 32-bit words; power of two.
- BASE_ADDR, 32'h8000_0000: byte address of word 0.
- LATENCY, 1: cycles from request acceptance to rsp_valid; legal range 1..4.
- NOP_INST, 32'h0000_0013: word returned on error responses.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  fetch request valid.
- req_ready  output  1  responder can accept a request this cycle.
- req_addr  input  32  fetch byte address (the core's pc).
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  consumer accepts the response.
- rsp_inst  output  32  instruction word.
- rsp_err  output  1  address outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS).
- ld_en  input  1  preload write enable.
- ld_idx  input  $clog2(DEPTH_WORDS)  preload word index.
- ld_data  input  32  preload data.

Behaviour:
- Reset: one clock, async active-high reset as decided.
  - While rst=1: state=IDLE, req_ready=0, rsp_valid=0, rsp_inst=0, rsp_err=0, latency counter=0.
  - Storage contents are not reset.
  - req_ready rises in the first cycle after rst deasserts.
- FSM states:
  - IDLE: req_ready=1, rsp_valid=0.
  - WAIT: req_ready=0, rsp_valid=0, counter counting down.
  - RESP: rsp_valid=1, holding rsp_inst and rsp_err.
- Transitions:
  - IDLE, accept (req_valid&req_ready): go to RESP if LATENCY==1, else WAIT with counter=LATENCY-1.
  - WAIT: decrement counter each cycle; when counter reaches 1, go to RESP next edge.
  - RESP with rsp_ready=1: handshake completes. If req_valid=1 in the same cycle, accept the new request (req_ready=rsp_ready in RESP) and reload as from IDLE; otherwise go to IDLE.
  - RESP with rsp_ready=0: hold. rsp_inst and rsp_err must stay stable until the handshake.
- Timing:
  - A request accepted at edge t gives rsp_valid=1 from edge t+LATENCY.
  - LATENCY=1 with rsp_ready tied high sustains one instruction per cycle.
- Address decode:
  - word index = (req_addr-BASE_ADDR)>>2, truncated to the index width.
  - Out-of-range address: rsp_err=1, rsp_inst=NOP_INST; storage is not read.
  - req_addr[1:0] is ignored unless the optional feature is enabled.
- Data capture:
  - Storage is read at the accepting edge; the result is held in the response register.
  - A later ld write to the same index does not alter a pending or held response.
  - ld write and request accept to the same index on the same edge: the response returns the OLD word (read-before-write).
- ld_en is legal in every state, including during reset; writes take effect at the edge.
- Reset mid-WAIT or mid-RESP: the pending response is dropped and the FSM returns to IDLE with all outputs as listed under Reset.

Optional Feature:
- Macro: YSYX_23060096_IMEM_MISALIGN_CHK_EN.
- Defined: req_addr[1:0]!=0 gives rsp_err=1 and rsp_inst=NOP_INST, with the same latency as a normal access.
- Undefined: the low two address bits are ignored and the aligned word is returned.

Decomposition:
- Package ysyx_23060096_imem_pkg:
  - state enum {IDLE, WAIT, RESP}.
  - NOP_INST default.
  - BASE_ADDR default.
  - MAX_LATENCY=4.
- Sub-module ysyx_23060096_imem_array: DEPTH_WORDS x 32 storage with one synchronous-write port (ld) and one combinational read port. The FSM, decode and response register live in the top.

Test Plan:
1. LATENCY=1, preload idx0=32'h00100093, idx1=32'h00200113, rsp_ready=1, requests 0x80000000 then 0x80000004 back-to-back -> rsp_valid on consecutive cycles with those words, rsp_err=0.
2. LATENCY=3, request 0x80000008 (idx2=32'hDEADBEEF) -> rsp_valid exactly 3 cycles after accept; req_ready=0 during WAIT.
3. Response held, rsp_ready=0 for 5 cycles, ld overwrites idx2 meanwhile -> rsp_inst stays 32'hDEADBEEF and stable; req_ready=0 until the handshake.
4. Request 0x7FFFFFFC and 0x80004000 (DEPTH 4096) -> rsp_err=1, rsp_inst=32'h00000013.
5. Assert rst during WAIT -> rsp_valid never rises; after release req_ready=1 next cycle and a fresh request completes normally.
6. Macro defined, request 0x80000002 -> rsp_err=1, rsp_inst=NOP. Macro undefined -> idx0 word, rsp_err=0.

Source files
------------

// File: rtl/ysyx_23060096_imem_pkg.sv
`default_nettype none
// ============================================================================
// Module : ysyx_23060096_imem_pkg
// Brief  : Shared types and defaults for the instruction-memory responder.
// Rev    : 1.0 - initial release
// ============================================================================
package ysyx_23060096_imem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } imem_state_e;

    localparam logic [31:0] c_NOP_INST    = 32'h0000_0013;
    localparam logic [31:0] c_BASE_ADDR   = 32'h8000_0000;
    localparam int unsigned c_MAX_LATENCY = 4;
    localparam int unsigned c_CNT_W       = $clog2(c_MAX_LATENCY + 1);

endpackage : ysyx_23060096_imem_pkg
`default_nettype wire

// File: rtl/ysyx_23060096_imem_array.sv
`default_nettype none
// ============================================================================
// Module : ysyx_23060096_imem_array
// Brief  : Word storage with one synchronous write port and one async read.
// Rev    : 1.0 - initial release
// ============================================================================
module ysyx_23060096_imem_array #(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic [31:0]      i_wr_data,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic [31:0]      o_rd_data
);

    // Contents survive reset so a preload done during reset is kept.
    logic [31:0] r_mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_idx] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_idx];

endmodule : ysyx_23060096_imem_array
`default_nettype wire

// File: rtl/ysyx_23060096_imem_resp.sv
`default_nettype none
// ============================================================================
// Module : ysyx_23060096_imem_resp
// Brief  : Fetch responder: valid/ready request in, instruction out after a
//          fixed latency. Optional macro YSYX_23060096_IMEM_MISALIGN_CHK_EN
//          flags non-word-aligned fetch addresses as errors.
// Rev    : 1.0 - initial release
// ============================================================================
module ysyx_23060096_imem_resp
    import ysyx_23060096_imem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR   = c_BASE_ADDR,
    parameter int unsigned LATENCY     = 1,
    parameter logic [31:0] NOP_INST    = c_NOP_INST
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_req_valid,
    output logic                           o_req_ready,
    input  logic [31:0]                    i_req_addr,
    output logic                           o_rsp_valid,
    input  logic                           i_rsp_ready,
    output logic [31:0]                    o_rsp_inst,
    output logic                           o_rsp_err,
    input  logic                           i_ld_en,
    input  logic [$clog2(DEPTH_WORDS)-1:0] i_ld_idx,
    input  logic [31:0]                    i_ld_data
);

    localparam int unsigned c_IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [32:0] c_SPAN  = 33'(DEPTH_WORDS) << 2;
    localparam int unsigned c_LAT   = (LATENCY < 1) ? 1 :
                                      (LATENCY > c_MAX_LATENCY) ? c_MAX_LATENCY : LATENCY;
    localparam logic [c_CNT_W-1:0] c_LOAD = c_CNT_W'(c_LAT - 1);

    imem_state_e        r_state;
    imem_state_e        w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic [31:0]        r_rsp_inst;
    logic               r_rsp_err;

    logic [31:0]        w_off;
    logic               w_in_range;
    logic               w_misalign;
    logic               w_err;
    logic [c_IDX_W-1:0] w_idx;
    logic [31:0]        w_rd_data;
    logic [31:0]        w_inst;
    logic               w_ready_raw;
    logic               w_accept;
    logic               w_unused_bits;

    // Unsigned wrap makes addresses below BASE_ADDR fall out of range too.
    assign w_off      = i_req_addr - BASE_ADDR;
    assign w_in_range = ({1'b0, w_off} < c_SPAN);
    assign w_idx      = w_off[c_IDX_W+1:2];

`ifdef YSYX_23060096_IMEM_MISALIGN_CHK_EN
    assign w_misalign = |i_req_addr[1:0];
`else
    assign w_misalign = 1'b0;
`endif

    assign w_err         = ~w_in_range | w_misalign;
    assign w_inst        = w_err ? NOP_INST : w_rd_data;
    assign w_unused_bits = ^{w_off[31:c_IDX_W+2], w_off[1:0]};

    ysyx_23060096_imem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (c_IDX_W)
    ) u_array (
        .clk       (clk),
        .i_wr_en   (i_ld_en),
        .i_wr_idx  (i_ld_idx),
        .i_wr_data (i_ld_data),
        .i_rd_idx  (w_idx),
        .o_rd_data (w_rd_data)
    );

    assign w_ready_raw = (r_state == ST_IDLE) || ((r_state == ST_RESP) && i_rsp_ready);
    assign o_req_ready = w_ready_raw & ~rst;
    assign w_accept    = i_req_valid & o_req_ready;
    assign o_rsp_valid = (r_state == ST_RESP);
    assign o_rsp_inst  = r_rsp_inst;
    assign o_rsp_err   = r_rsp_err;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            ST_IDLE, ST_RESP: begin
                if (w_accept) begin
                    w_state_nxt = (c_LAT == 1) ? ST_RESP : ST_WAIT;
                    w_cnt_nxt   = c_LOAD;
                end else if ((r_state == ST_RESP) && i_rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (r_cnt <= c_CNT_W'(1)) begin
                    w_state_nxt = ST_RESP;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt - c_CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Response is captured at the accepting edge so later preloads cannot touch it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_rsp_inst <= '0;
            r_rsp_err  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_rsp_inst <= w_inst;
                r_rsp_err  <= w_err;
            end
        end
    end

endmodule : ysyx_23060096_imem_resp
`default_nettype wire

// File: tb/tb_ysyx_23060096_imem_resp.sv
`default_nettype none
// ============================================================================
// Module : tb_ysyx_23060096_imem_resp
// Brief  : Randomized self-checking bench; one responder at latency 1 and one
//          at latency 3 share the preload port and reset.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_ysyx_23060096_imem_resp;

    localparam int          DEPTH = 4096;
    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ld_en = 1'b0;
    logic [11:0] ld_idx = '0;
    logic [31:0] ld_data = '0;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready = '0;
    logic [1:0]  rsp_err;
    logic [31:0] req_addr [2] = '{32'h0, 32'h0};
    logic [31:0] rsp_inst [2];

    int          lat_of [2] = '{1, 3};
    logic [31:0] mem_m [DEPTH];
    int          n_total = 0;
    int          n_bad   = 0;

    always #5 clk = ~clk;

    ysyx_23060096_imem_resp #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) u_dut_l1 (
        .clk(clk), .rst(rst),
        .i_req_valid(req_valid[0]), .o_req_ready(req_ready[0]), .i_req_addr(req_addr[0]),
        .o_rsp_valid(rsp_valid[0]), .i_rsp_ready(rsp_ready[0]),
        .o_rsp_inst(rsp_inst[0]), .o_rsp_err(rsp_err[0]),
        .i_ld_en(ld_en), .i_ld_idx(ld_idx), .i_ld_data(ld_data)
    );

    ysyx_23060096_imem_resp #(.DEPTH_WORDS(DEPTH), .LATENCY(3)) u_dut_l3 (
        .clk(clk), .rst(rst),
        .i_req_valid(req_valid[1]), .o_req_ready(req_ready[1]), .i_req_addr(req_addr[1]),
        .o_rsp_valid(rsp_valid[1]), .i_rsp_ready(rsp_ready[1]),
        .o_rsp_inst(rsp_inst[1]), .o_rsp_err(rsp_err[1]),
        .i_ld_en(ld_en), .i_ld_idx(ld_idx), .i_ld_data(ld_data)
    );

    // Reference storage follows the preload port; reads happen before the edge.
    always @(posedge clk) begin
        if (ld_en) mem_m[ld_idx] = ld_data;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Returns {err, inst} for a fetch address, from the address-map rules.
    function automatic logic [32:0] ref_rsp(input logic [31:0] a);
        longint off;
        off = longint'({32'b0, a}) - longint'({32'b0, BASE});
        if (off < 0 || off >= 4 * DEPTH) return {1'b1, NOP};
`ifdef YSYX_23060096_IMEM_MISALIGN_CHK_EN
        if (a[1:0] != 2'b00) return {1'b1, NOP};
`endif
        return {1'b0, mem_m[off / 4]};
    endfunction

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 9))
            0:       return 32'h7FFF_FFFC - ($urandom_range(0, 15) << 2);
            1:       return 32'h8000_4000 + ($urandom_range(0, 15) << 2);
            2:       return BASE + ($urandom_range(0, DEPTH - 1) << 2) + $urandom_range(1, 3);
            default: return BASE + ($urandom_range(0, DEPTH - 1) << 2);
        endcase
    endfunction

    // One request on responder k, held for 'stall' cycles while preloads hit
    // the same word; optionally a preload to the same word on the accept edge.
    task automatic txn(input int k, input logic [31:0] a, input int stall, input bit ld_same);
        logic [32:0] e;
        logic [11:0] idx;
        int          n;
        @(negedge clk);
        n = 0;
        while (!req_ready[k] && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready_idle", 64'(req_ready[k]), 64'd1);
        e   = ref_rsp(a);
        idx = 12'((a - BASE) >> 2);
        req_valid[k] = 1'b1;
        req_addr[k]  = a;
        rsp_ready[k] = 1'b0;
        if (ld_same) begin
            ld_en = 1'b1; ld_idx = idx; ld_data = $urandom;
        end
        @(negedge clk);
        req_valid[k] = 1'b0;
        ld_en        = 1'b0;
        n = 1;
        while (!rsp_valid[k] && n < 10) begin
            chk("ready_in_wait", 64'(req_ready[k]), 64'd0);
            @(negedge clk);
            n++;
        end
        chk("latency", 64'(n), 64'(lat_of[k]));
        chk("rsp_inst", 64'(rsp_inst[k]), 64'(e[31:0]));
        chk("rsp_err", 64'(rsp_err[k]), 64'(e[32]));
        for (int s = 0; s < stall; s++) begin
            ld_en = 1'b1; ld_idx = idx; ld_data = ~e[31:0] ^ $urandom;
            @(negedge clk);
            ld_en = 1'b0;
            chk("hold_valid", 64'(rsp_valid[k]), 64'd1);
            chk("hold_inst", 64'(rsp_inst[k]), 64'(e[31:0]));
            chk("hold_err", 64'(rsp_err[k]), 64'(e[32]));
            chk("hold_ready", 64'(req_ready[k]), 64'd0);
        end
        rsp_ready[k] = 1'b1;
        @(negedge clk);
        rsp_ready[k] = 1'b0;
        chk("after_hs_valid", 64'(rsp_valid[k]), 64'd0);
    endtask

    initial begin
        logic [32:0] e;
        logic [31:0] a;

        // Preload every word while reset is held; the preload port is live in reset.
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            ld_en = 1'b1; ld_idx = 12'(i); ld_data = $urandom;
            if (i == 0) ld_data = 32'h0010_0093;
            if (i == 1) ld_data = 32'h0020_0113;
            if (i == 2) ld_data = 32'hDEAD_BEEF;
        end
        @(negedge clk);
        ld_en = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk("rst_rsp_valid", 64'(rsp_valid[k]), 64'd0);
            chk("rst_req_ready", 64'(req_ready[k]), 64'd0);
            chk("rst_rsp_inst", 64'(rsp_inst[k]), 64'd0);
            chk("rst_rsp_err", 64'(rsp_err[k]), 64'd0);
        end
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 64'(req_ready[0]), 64'd1);

        // Back-to-back stream at latency 1 with the consumer always ready.
        @(negedge clk);
        rsp_ready[0] = 1'b1;
        for (int i = 0; i < 12; i++) begin
            a = (i == 0) ? 32'h8000_0000 : (i == 1) ? 32'h8000_0004 : rand_addr();
            e = ref_rsp(a);
            req_valid[0] = 1'b1;
            req_addr[0]  = a;
            @(negedge clk);
            chk("b2b_valid", 64'(rsp_valid[0]), 64'd1);
            chk("b2b_inst", 64'(rsp_inst[0]), 64'(e[31:0]));
            chk("b2b_err", 64'(rsp_err[0]), 64'(e[32]));
            chk("b2b_ready", 64'(req_ready[0]), 64'd1);
        end
        req_valid[0] = 1'b0;
        @(negedge clk);
        rsp_ready[0] = 1'b0;
        chk("b2b_drain", 64'(rsp_valid[0]), 64'd0);

        // Directed cases: latency 3, held response under overwrite, errors, misalign.
        txn(1, 32'h8000_0008, 5, 1'b0);
        txn(1, 32'h7FFF_FFFC, 1, 1'b0);
        txn(0, 32'h8000_4000, 2, 1'b0);
        txn(0, 32'h8000_0002, 0, 1'b0);
        txn(1, 32'h8000_0002, 0, 1'b0);
        txn(0, 32'h8000_0010, 1, 1'b1);

        // Reset while the latency-3 responder is waiting.
        @(negedge clk);
        req_valid[1] = 1'b1;
        req_addr[1]  = 32'h8000_0008;
        @(negedge clk);
        req_valid[1] = 1'b0;
        chk("wait_ready", 64'(req_ready[1]), 64'd0);
        rst = 1'b1;
        #1;
        chk("midrst_valid", 64'(rsp_valid[1]), 64'd0);
        chk("midrst_ready", 64'(req_ready[1]), 64'd0);
        chk("midrst_inst", 64'(rsp_inst[1]), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rel_ready", 64'(req_ready[1]), 64'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("dropped_rsp", 64'(rsp_valid[1]), 64'd0);
        end
        txn(1, 32'h8000_0004, 0, 1'b0);

        // Randomized traffic on both responders.
        for (int i = 0; i < 40; i++) begin
            txn(i % 2, rand_addr(), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout got=%0d exp=%0d", 0, 1);
        $fatal(1);
    end

endmodule : tb_ysyx_23060096_imem_resp
`default_nettype wire
